// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D): data-first, fetch anti-starvation; 2+ cycles request-to-ready.
// Requesters hold until their ready pulse; optional watchdog (MEM_ARB_TIMEOUT_EN) aborts stuck transfers and sets m_error.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic              d_isbyte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_enable,
  output logic              m_rw,
  output logic              m_isbyte,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_data_in,
  input  logic [DATA_W-1:0] m_data_out,
  input  logic              m_ready,
  output logic              m_error
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          grant_d;
  logic          grant_i;
  logic          xfer_done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wdog;
`else
  assign m_error = 1'b0;
`endif

  always_comb begin
    grant_d   = d_req && (!i_req || (streak < LIMIT));
    grant_i   = i_req && !grant_d;
`ifdef MEM_ARB_TIMEOUT_EN
    xfer_done = m_ready || (wdog == WD_LAST);
`else
    xfer_done = m_ready;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      m_enable  <= 1'b0;
      m_rw      <= 1'b0;
      m_isbyte  <= 1'b0;
      m_address <= '0;
      m_data_in <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wdog      <= '0;
      m_error   <= 1'b0;
`endif
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (!i_req) streak <= '0;
      case (state)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          wdog <= '0;
`endif
          if (grant_d) begin
            state     <= BUSY_D;
            m_enable  <= 1'b1;
            m_rw      <= d_rw;
            m_isbyte  <= d_isbyte;
            m_address <= d_addr;
            m_data_in <= d_wdata;
            // grant_d with i_req pending implies streak < LIMIT, so no overflow
            if (i_req) streak <= streak + 1'b1;
          end else if (grant_i) begin
            state     <= BUSY_I;
            m_enable  <= 1'b1;
            m_rw      <= 1'b0;
            m_isbyte  <= 1'b0;
            m_address <= i_addr;
            m_data_in <= '0;
            streak    <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (xfer_done) begin
            state    <= IDLE;
            m_enable <= 1'b0;
            if (state == BUSY_I) begin
              i_ready <= 1'b1;
              i_rdata <= m_ready ? m_data_out : '0;
            end else begin
              d_ready <= 1'b1;
              // stores leave the last load result visible
              if (!m_rw) d_rdata <= m_ready ? m_data_out : '0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            if (!m_ready) m_error <= 1'b1;
`endif
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model plus directed literal checks.
module tb_mem_port_arbiter;
  localparam int LIMIT      = 4;
  localparam int TB_TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req = 1'b0, d_rw = 1'b0, d_isbyte = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_enable, m_rw, m_isbyte, m_error;
  logic [31:0] m_address, m_data_in;
  logic [31:0] m_data_out = '0;
  logic        m_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          busy = 0, own_d = 0, new_xfer = 0;
  int          streak = 0, wd = 0;
  logic        e_i_ready = 0, e_d_ready = 0, e_m_enable = 0, e_m_rw = 0, e_m_isbyte = 0, e_m_error = 0;
  logic [31:0] e_i_rdata = '0, e_d_rdata = '0, e_m_address = '0, e_m_data_in = '0;

  // memory responder controls
  int          lat_left = 0;
  int          forced_lat = -1;
  bit          use_forced = 0;
  logic [31:0] forced_data = '0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)
`ifdef MEM_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(TB_TIMEOUT)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_rw(d_rw), .d_isbyte(d_isbyte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_enable(m_enable), .m_rw(m_rw), .m_isbyte(m_isbyte), .m_address(m_address),
    .m_data_in(m_data_in), .m_data_out(m_data_out), .m_ready(m_ready), .m_error(m_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic complete(input logic [31:0] data);
    busy       = 0;
    e_m_enable = 0;
    if (own_d) begin
      e_d_ready = 1;
      if (!e_m_rw) e_d_rdata = data;
    end else begin
      e_i_ready = 1;
      e_i_rdata = data;
    end
  endtask

  // Reference: one transfer at a time, data wins unless fetch has lost LIMIT times in a row.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy = 0; new_xfer = 0; streak = 0; wd = 0;
      e_i_ready = 0; e_d_ready = 0; e_m_enable = 0; e_m_rw = 0; e_m_isbyte = 0; e_m_error = 0;
      e_i_rdata = '0; e_d_rdata = '0; e_m_address = '0; e_m_data_in = '0;
    end else begin
      e_i_ready = 0;
      e_d_ready = 0;
      if (!busy) begin
        if (d_req && (!i_req || streak < LIMIT)) begin
          busy = 1; own_d = 1;
          e_m_rw = d_rw; e_m_isbyte = d_isbyte; e_m_address = d_addr; e_m_data_in = d_wdata;
          streak = i_req ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
        end else if (i_req) begin
          busy = 1; own_d = 0;
          e_m_rw = 0; e_m_isbyte = 0; e_m_address = i_addr; e_m_data_in = '0;
          streak = 0;
        end else begin
          streak = 0;
        end
        if (busy) begin
          e_m_enable = 1; new_xfer = 1; wd = 0;
        end
      end else begin
        if (!i_req) streak = 0;
        if (m_ready) complete(m_data_out);
        else begin
          wd++;
`ifdef MEM_ARB_TIMEOUT_EN
          if (wd >= TB_TIMEOUT) begin
            complete('0);
            e_m_error = 1;
          end
`endif
        end
      end
    end
  end

  // Single compare process: every output against the model on each falling edge.
  always @(negedge clock) begin
    chk("i_ready",   64'(i_ready),   64'(e_i_ready));
    chk("i_rdata",   64'(i_rdata),   64'(e_i_rdata));
    chk("d_ready",   64'(d_ready),   64'(e_d_ready));
    chk("d_rdata",   64'(d_rdata),   64'(e_d_rdata));
    chk("m_enable",  64'(m_enable),  64'(e_m_enable));
    chk("m_rw",      64'(m_rw),      64'(e_m_rw));
    chk("m_isbyte",  64'(m_isbyte),  64'(e_m_isbyte));
    chk("m_address", 64'(m_address), 64'(e_m_address));
    chk("m_data_in", 64'(m_data_in), 64'(e_m_data_in));
    chk("m_error",   64'(m_error),   64'(e_m_error));
  end

  // Advance to the next falling edge and drive the memory response for the coming edge.
  task automatic cycle();
    @(negedge clock);
    if (new_xfer) begin
      lat_left = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
      new_xfer = 0;
    end
    if (busy && lat_left == 0) begin
      m_ready    = 1'b1;
      m_data_out = use_forced ? forced_data : $urandom;
    end else begin
      m_ready = 1'b0;
      if (busy) lat_left--;
    end
  endtask

  logic [5:0]  seq;
  int          ngrant;
  logic        prev_en;
  logic [31:0] saved_rd;

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // fetch with single-cycle memory
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h8002_0000;
    use_forced = 1; forced_data = 32'h2108_000A; forced_lat = 0;
    cycle();
    chk("t1_m_address", 64'(m_address), 64'h8002_0000);
    chk("t1_m_enable", 64'(m_enable), 64'd1);
    cycle();
    chk("t1_i_ready", 64'(i_ready), 64'd1);
    chk("t1_i_rdata", 64'(i_rdata), 64'h2108_000A);
    i_req = 1'b0; use_forced = 0;
    cycle();

    // simultaneous requests: data first, then fetch
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h100;
    cycle();
    chk("t2_first_grant", 64'(m_address), 64'h100);
    cycle();
    chk("t2_d_ready", 64'(d_ready), 64'd1);
    d_req = 1'b0;
    cycle();
    chk("t2_second_grant", 64'(m_address), 64'h200);
    cycle();
    chk("t2_i_ready", 64'(i_ready), 64'd1);
    i_req = 1'b0;
    cycle();

    // both held: D x4, then I, then D again
    i_req = 1'b1; d_req = 1'b1;
    seq = '0; ngrant = 0; prev_en = 1'b0;
    repeat (12) begin
      cycle();
      if (m_enable && !prev_en) begin
        seq = {seq[4:0], m_address == 32'h100};
        ngrant++;
      end
      prev_en = m_enable;
    end
    chk("t3_grant_order", 64'(seq), 64'b111101);
    chk("t3_grant_count", 64'(ngrant), 64'd6);
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) cycle();

    // byte store with 3-cycle memory latency
    saved_rd = e_d_rdata;
    d_req = 1'b1; d_rw = 1'b1; d_isbyte = 1'b1; d_addr = 32'h7; d_wdata = 32'hAB;
    forced_lat = 3;
    cycle();
    for (int k = 0; k < 4; k++) begin
      chk("t4_ctl_stable", 64'({m_enable, m_rw, m_isbyte}), 64'b111);
      chk("t4_addr_stable", 64'(m_address), 64'h7);
      chk("t4_data_stable", 64'(m_data_in), 64'hAB);
      chk("t4_no_early_ready", 64'(d_ready), 64'd0);
      cycle();
    end
    chk("t4_d_ready", 64'(d_ready), 64'd1);
    chk("t4_d_rdata_kept", 64'(d_rdata), 64'(saved_rd));
    d_req = 1'b0; d_rw = 1'b0; d_isbyte = 1'b0;
    cycle();
    chk("t4_d_ready_once", 64'(d_ready), 64'd0);

    // reset during a stalled data transfer
    d_req = 1'b1; d_addr = 32'h40; forced_lat = 1000;
    cycle();
    chk("t5_m_enable_busy", 64'(m_enable), 64'd1);
    cycle();
    #2 reset = 1'b1;
    #1;
    chk("t5_m_enable_async", 64'(m_enable), 64'd0);
    chk("t5_no_d_ready", 64'(d_ready), 64'd0);
    d_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    cycle();
    chk("t5_idle_enable", 64'(m_enable), 64'd0);
    chk("t5_idle_d_ready", 64'(d_ready), 64'd0);
    i_req = 1'b1; i_addr = 32'h300; forced_lat = 0;
    cycle();
    chk("t5_regrant_addr", 64'(m_address), 64'h300);
    cycle();
    chk("t5_regrant_ready", 64'(i_ready), 64'd1);
    i_req = 1'b0;
    forced_lat = -1;
    cycle();

    // random traffic against the model
    repeat (3000) begin
      cycle();
      if (i_req) begin
        if (e_i_ready) begin
          if ($urandom_range(0, 2) == 0) i_addr = $urandom;
          else i_req = 1'b0;
        end else if ($urandom_range(0, 31) == 0) i_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (d_req) begin
        if (e_d_ready) begin
          if ($urandom_range(0, 2) == 0) begin
            d_rw = 1'($urandom); d_isbyte = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
          end else d_req = 1'b0;
        end else if ($urandom_range(0, 31) == 0) d_req = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_rw = 1'($urandom); d_isbyte = 1'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (8) cycle();

`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog: memory never answers
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h1000; forced_lat = 1000;
    cycle();
    for (int k = 1; k < TB_TIMEOUT; k++) begin
      cycle();
      chk("t6_no_early_ready", 64'(i_ready), 64'd0);
    end
    cycle();
    chk("t6_i_ready", 64'(i_ready), 64'd1);
    chk("t6_i_rdata", 64'(i_rdata), 64'd0);
    chk("t6_m_error", 64'(m_error), 64'd1);
    i_req = 1'b0;
    repeat (3) cycle();
    chk("t6_m_error_sticky", 64'(m_error), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_m_error_cleared", 64'(m_error), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    forced_lat = -1;
    cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
